uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one CoreUART transmitter among NUM_CH byte-stream requesters. Round-robin
//  grant per packet (lock held until ch_last byte), drives WEN/DATA_IN of the UART,
//  paces writes on TXRDY. Sits between on-chip producers (debug, status, pixel stats) and COREUART_C0.
// PARAMETERS
//  NUM_CH       4     number of requester channels, legal 2..8
//  ACK_TIMEOUT  255   max cycles waiting for TXRDY to fall after a write, legal 1..65535
// PORTS
//  CLK          in   1          system clock, all logic on rising edge
//  RESET_N      in   1          asynchronous active-low reset
//  ch_valid     in   NUM_CH     channel i has a byte on ch_data[8i+7:8i]
//  ch_data      in   8*NUM_CH   packed channel bytes
//  ch_last      in   NUM_CH     byte of channel i is last of its packet
//  ch_ready     out  NUM_CH     one-hot pulse: byte of channel i consumed this cycle
//  uart_txrdy   in   1          CoreUART TXRDY (1 = holding register free)
//  uart_wen     out  1          CoreUART WEN, single-cycle active-high pulse
//  uart_data    out  8          CoreUART DATA_IN, valid when uart_wen=1
//  grant_id     out  clog2(NUM_CH) current/last granted channel
//  busy         out  1          1 while a packet is locked or a byte is in flight
//  timeout_err  out  1          sticky: TXRDY failed to fall within ACK_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rr pointer = NUM_CH-1 (channel 0 wins first); lock=0.
//  States: IDLE, WRITE, WAIT_ACK, WAIT_RDY (plus HDR when macro enabled).
//  IDLE: if |ch_valid & uart_txrdy: grant first valid channel searching from rr+1 mod NUM_CH,
//   register grant_id, update rr=grant, lock=1, busy=1 -> WRITE. Else stay.
//  WRITE (1 cycle): uart_wen=1, uart_data=ch_data[grant], ch_ready[grant]=1; capture
//   ch_last[grant] -> eop; clear timeout counter -> WAIT_ACK.
//  WAIT_ACK: on uart_txrdy=0 -> WAIT_RDY. Counter counts cycles; at ACK_TIMEOUT without
//   fall: set timeout_err, -> WAIT_RDY anyway (byte considered accepted).
//  WAIT_RDY: wait uart_txrdy=1. Then: eop=1 -> lock=0, busy=0, -> IDLE (re-arbitration
//   next cycle, earliest grant 1 cycle later). eop=0 -> stay until ch_valid[grant]=1,
//   then -> WRITE same channel; other channels never interleave mid-packet.
//  Latency: grant->WEN 1 cycle; min 4 cycles between consecutive WEN pulses.
//  uart_wen never asserted while uart_txrdy=0 was last sampled in WAIT_ACK/WAIT_RDY.
//  ch_ready asserted only in WRITE, only for grant; a deasserted ch_valid during lock
//   just stalls (no timeout). ch_data/ch_last sampled only in the WRITE cycle.
//  Round-robin wrap: rr=NUM_CH-1 searches from channel 0. Single requester re-wins
//   each packet. Simultaneous requests resolved purely by rr order.
//  timeout_err cleared only by RESET_N. Reset mid-packet: lock dropped, no partial
//   WEN; producers must restart their packet.
// CONFIGURATION
//  UART_TX_ARB_CHID_EN defined: on each new grant from IDLE, state HDR inserted before
//   first WRITE: one extra WEN with uart_data={4'hA,1'b0,grant_id zero-extended to 3b},
//   ch_ready stays 0, same WAIT_ACK/WAIT_RDY pacing, then payload WRITE.
//  Undefined: no header state; payload bytes only; HDR logic absent from netlist.
// TESTING
//  Reset, ch_valid=0, txrdy=1 -> uart_wen=0, ch_ready=0, busy=0, grant_id=0 for 50 cycles.
//  ch0 sends 3 bytes 11,22,33(last) with UART model dropping TXRDY 1 cycle after WEN,
//   raising 20 cycles later -> exactly 3 WEN pulses, data 11,22,33, spacing >=22 cycles.
//  ch1 and ch2 both valid 1-byte packets continuously -> grants alternate 1,2,1,2;
//   with ch0..ch3 all valid from reset -> order 0,1,2,3,0.
//  ch0 mid-packet (last=0) stalls 100 cycles while ch3 valid -> no WEN to ch3 until
//   ch0 sends last byte; ch3 granted next.
//  UART model holds TXRDY=1 after WEN -> timeout_err=1 after ACK_TIMEOUT+1 cycles,
//   arbiter proceeds; RESET_N pulse mid-WAIT_RDY -> all outputs 0 next cycle.
//  With UART_TX_ARB_CHID_EN, ch2 sends 0x5C(last) -> WEN data 0xA2 then 0x5C, one ch_ready.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side byte streams and the CoreUART write port that
//   uart_tx_arbiter sits between.
//
//   Signals
//     ch_valid   [NUM_CH]    channel i presents a byte on ch_data[8i+7:8i]
//     ch_data    [8*NUM_CH]  packed channel bytes
//     ch_last    [NUM_CH]    byte of channel i closes its packet
//     ch_ready   [NUM_CH]    one-hot pulse: byte of channel i consumed
//     uart_txrdy             CoreUART TXRDY (1 = holding register free)
//     uart_wen               CoreUART WEN, single-cycle pulse
//     uart_data  [8]         CoreUART DATA_IN, valid while uart_wen=1
//
//   Modports
//     master : producers + UART side (environment)
//     slave  : the arbiter
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]   ch_valid;
   logic [8*NUM_CH-1:0] ch_data;
   logic [NUM_CH-1:0]   ch_last;
   logic [NUM_CH-1:0]   ch_ready;
   logic                uart_txrdy;
   logic                uart_wen;
   logic [7:0]          uart_data;

   modport master (
      output ch_valid,
      output ch_data,
      output ch_last,
      output uart_txrdy,
      input  ch_ready,
      input  uart_wen,
      input  uart_data
   );

   modport slave (
      input  ch_valid,
      input  ch_data,
      input  ch_last,
      input  uart_txrdy,
      output ch_ready,
      output uart_wen,
      output uart_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one CoreUART transmitter among NUM_CH byte-stream requesters.
//   Round-robin grant per packet; the grant stays locked on one channel until
//   its ch_last byte has been written. Every write is paced on TXRDY: after a
//   WEN pulse the arbiter waits for TXRDY to fall (bounded by ACK_TIMEOUT) and
//   then to rise again before the next write.
//
//   Ports
//     CLK          system clock, rising edge
//     RESET_N      asynchronous active-low reset
//     bus          uart_tx_arbiter_if.slave (channel streams + UART write port)
//     grant_id     current / last granted channel
//     busy         a packet is locked or a byte is in flight
//     timeout_err  sticky: TXRDY did not fall within ACK_TIMEOUT cycles
//
//   Optional feature (macro UART_TX_ARB_CHID_EN)
//     When defined, every new grant from IDLE first emits one header byte
//     {4'hA, 1'b0, grant_id[2:0]} with the same TXRDY pacing and no ch_ready,
//     followed by the payload bytes. When undefined the header state and its
//     logic do not exist.
//
//   Timing
//     All outputs are registered: a decision taken in state WRITE (or HDR)
//     shows up on uart_wen/uart_data/ch_ready in the following cycle, so the
//     grant-to-WEN latency is one cycle and consecutive WEN pulses are at
//     least four cycles apart.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                      CLK,
   input  logic                      RESET_N,
   uart_tx_arbiter_if.slave          bus,
   output logic [$clog2(NUM_CH)-1:0] grant_id,
   output logic                      busy,
   output logic                      timeout_err
);
   localparam int          IDW     = $clog2(NUM_CH);
   // Last counter value still inside the acknowledge window.
   localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      WAIT_ACK = 3'd2,
`ifdef UART_TX_ARB_CHID_EN
      HDR      = 3'd4,
`endif
      WAIT_RDY = 3'd3
   } state_t;

   state_t            state_reg;
   logic [IDW-1:0]    rr_reg;
   logic [IDW-1:0]    grant_reg;
   logic              eop_reg;
   logic [15:0]       ack_cnt_reg;
   logic              wen_reg;
   logic [7:0]        data_reg;
   logic [NUM_CH-1:0] ch_ready_reg;
   logic              busy_reg;
   logic              timeout_err_reg;

   // Unpacked view of the channel bytes for indexed selection.
   logic [7:0] ch_byte [NUM_CH];

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
         assign ch_byte[gi] = bus.ch_data[8*gi +: 8];
      end
   endgenerate

   // Round-robin search starting at rr+1. Iterating from the farthest
   // candidate down to the nearest lets the nearest valid channel win
   // without an early loop exit.
   logic           pick_found;
   logic [IDW-1:0] pick_id;

   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         logic [IDW-1:0] idx;
         idx = IDW'((int'(rr_reg) + k) % NUM_CH);
         if (bus.ch_valid[idx]) begin
            pick_found = 1'b1;
            pick_id    = idx;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_reg       <= IDLE;
         rr_reg          <= IDW'(NUM_CH - 1);
         grant_reg       <= '0;
         eop_reg         <= 1'b0;
         ack_cnt_reg     <= '0;
         wen_reg         <= 1'b0;
         data_reg        <= '0;
         ch_ready_reg    <= '0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         // WEN and ch_ready are single-cycle pulses by construction.
         wen_reg      <= 1'b0;
         ch_ready_reg <= '0;

         case (state_reg)
            IDLE: begin
               if (pick_found && bus.uart_txrdy) begin
                  grant_reg <= pick_id;
                  rr_reg    <= pick_id;
                  busy_reg  <= 1'b1;   // busy doubles as the packet lock
`ifdef UART_TX_ARB_CHID_EN
                  state_reg <= HDR;
`else
                  state_reg <= WRITE;
`endif
               end
            end

`ifdef UART_TX_ARB_CHID_EN
            HDR: begin
               wen_reg     <= 1'b1;
               data_reg    <= {4'hA, 1'b0, 3'(grant_reg)};
               // Not end-of-packet: WAIT_RDY then waits for the payload byte.
               eop_reg     <= 1'b0;
               ack_cnt_reg <= '0;
               state_reg   <= WAIT_ACK;
            end
`endif

            WRITE: begin
               wen_reg                 <= 1'b1;
               data_reg                <= ch_byte[grant_reg];
               ch_ready_reg[grant_reg] <= 1'b1;
               eop_reg                 <= bus.ch_last[grant_reg];
               ack_cnt_reg             <= '0;
               state_reg               <= WAIT_ACK;
            end

            WAIT_ACK: begin
               if (!bus.uart_txrdy) begin
                  state_reg <= WAIT_RDY;
               end else if (ack_cnt_reg == TO_LAST) begin
                  // UART never acknowledged; treat the byte as taken.
                  timeout_err_reg <= 1'b1;
                  state_reg       <= WAIT_RDY;
               end else begin
                  ack_cnt_reg <= ack_cnt_reg + 16'd1;
               end
            end

            WAIT_RDY: begin
               if (bus.uart_txrdy) begin
                  if (eop_reg) begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
                  end else if (bus.ch_valid[grant_reg]) begin
                     state_reg <= WRITE;
                  end
               end
            end

            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.uart_wen  = wen_reg;
   assign bus.uart_data = data_reg;
   assign bus.ch_ready  = ch_ready_reg;
   assign grant_id      = grant_reg;
   assign busy          = busy_reg;
   assign timeout_err   = timeout_err_reg;
endmodule
